// File: rtl/tag_issue_ctrl.sv
// tag_issue_ctrl: issues tag req/reuse/flush pulses and routes stage done/ready signals over a tag_logic pool
module tag_issue_ctrl #(
  parameter int NUM_TAGS = 2,
  parameter int MAX_USES = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_reuse,
  input  logic                cmd_flush,
  input  logic                cmd_bias_prev_sw,
  input  logic                cmd_ddr_pe_sw,
  output logic [NUM_TAGS-1:0] tag_req,
  output logic [NUM_TAGS-1:0] tag_reuse,
  output logic [NUM_TAGS-1:0] tag_flush,
  output logic                tag_bias_prev_sw,
  output logic                tag_ddr_pe_sw,
  input  logic [NUM_TAGS-1:0] tag_ready,
  input  logic [NUM_TAGS-1:0] ldmem_tag_ready,
  output logic [NUM_TAGS-1:0] ldmem_tag_done,
  input  logic [NUM_TAGS-1:0] compute_tag_ready,
  output logic [NUM_TAGS-1:0] compute_tag_done,
  input  logic [NUM_TAGS-1:0] next_compute_tag,
  input  logic [NUM_TAGS-1:0] compute_bias_prev_sw,
  input  logic [NUM_TAGS-1:0] stmem_tag_ready,
  output logic [NUM_TAGS-1:0] stmem_tag_done,
  input  logic [NUM_TAGS-1:0] stmem_ddr_pe_sw,
  output logic                ldmem_ready,
  input  logic                ldmem_done,
  output logic                compute_ready,
  input  logic                compute_done,
  output logic                compute_bias_sw,
  output logic                stmem_ready,
  input  logic                stmem_done,
  output logic                stmem_sw,
  output logic                drained,
  output logic                proto_err
);
  localparam int PW = NUM_TAGS > 1 ? $clog2(NUM_TAGS) : 1;
  localparam logic [PW-1:0] LAST = PW'(NUM_TAGS - 1);
  localparam logic [NUM_TAGS-1:0] ONE = NUM_TAGS'(1);
  typedef enum logic [1:0] {IDLE, OPEN, FLUSH} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] ip_q, ip_d, lp_q, lp_d, cp_q, cp_d, sp_q, sp_d;
  logic [PW-1:0] lpx, cpx, spx;
  logic [3:0] uses_q [NUM_TAGS];
  logic [3:0] uses_d [NUM_TAGS];
  logic err_q, err_d;
  logic accept, ld_ok, cp_ok, st_ok;
  logic [NUM_TAGS-1:0] inc;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == LAST ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    lpx = reset ? '0 : lp_q;
    cpx = reset ? '0 : cp_q;
    spx = reset ? '0 : sp_q;
    ldmem_ready = ldmem_tag_ready[lpx];
    compute_ready = compute_tag_ready[cpx];
    stmem_ready = stmem_tag_ready[spx];
    compute_bias_sw = compute_bias_prev_sw[cpx];
    stmem_sw = stmem_ddr_pe_sw[spx];
    tag_bias_prev_sw = !reset && cmd_bias_prev_sw;
    tag_ddr_pe_sw = !reset && cmd_ddr_pe_sw;
    cmd_ready = reset ? 1'b0 :
                state_q == IDLE ? (cmd_reuse || tag_ready[ip_q]) :
                state_q == OPEN ? (cmd_reuse && uses_q[ip_q] < 4'(MAX_USES)) : 1'b0;
    accept = cmd_valid && cmd_ready;
    tag_req = (accept && state_q == IDLE && !cmd_reuse) ? ONE << ip_q : '0;
    tag_reuse = (accept && state_q == OPEN) ? ONE << ip_q : '0;
    tag_flush = (!reset && (state_q == FLUSH || (state_q == OPEN && cmd_valid && !cmd_reuse))) ? ONE << ip_q : '0;
    ld_ok = !reset && ldmem_done && ldmem_ready;
    cp_ok = !reset && compute_done && compute_ready;
    st_ok = !reset && stmem_done && stmem_ready;
    ldmem_tag_done = ld_ok ? ONE << lp_q : '0;
    compute_tag_done = cp_ok ? ONE << cp_q : '0;
    stmem_tag_done = st_ok ? ONE << sp_q : '0;
    drained = !reset && state_q == IDLE && &tag_ready;
    proto_err = !reset && err_q;
    state_d = state_q;
    ip_d = ip_q;
    if (|tag_flush) begin
      state_d = IDLE;
      ip_d = nxt(ip_q);
    end else if (|tag_req) begin
      state_d = cmd_flush ? FLUSH : OPEN;
    end else if (|tag_reuse && cmd_flush) begin
      state_d = FLUSH;
    end
    lp_d = ld_ok ? nxt(lp_q) : lp_q;
    cp_d = next_compute_tag[cp_q] ? nxt(cp_q) : cp_q;
    sp_d = st_ok ? nxt(sp_q) : sp_q;
    err_d = err_q || (accept && state_q == IDLE && cmd_reuse) ||
            (ldmem_done && !ldmem_ready) || (compute_done && !compute_ready) ||
            (stmem_done && !stmem_ready);
    inc = tag_req | tag_reuse;
    for (int t = 0; t < NUM_TAGS; t++) begin
      uses_d[t] = inc[t] == compute_tag_done[t] ? uses_q[t] :
                  inc[t] ? uses_q[t] + 4'd1 :
                  uses_q[t] == 4'd0 ? 4'd0 : uses_q[t] - 4'd1;
      err_d = err_d || (compute_tag_done[t] && !inc[t] && uses_q[t] == 4'd0);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ip_q <= '0;
      lp_q <= '0;
      cp_q <= '0;
      sp_q <= '0;
      err_q <= 1'b0;
      for (int t = 0; t < NUM_TAGS; t++) uses_q[t] <= '0;
    end else begin
      state_q <= state_d;
      ip_q <= ip_d;
      lp_q <= lp_d;
      cp_q <= cp_d;
      sp_q <= sp_d;
      err_q <= err_d;
      for (int t = 0; t < NUM_TAGS; t++) uses_q[t] <= uses_d[t];
    end
  end
endmodule

// File: tb/tb_tag_issue_ctrl.sv
// tb_tag_issue_ctrl: randomized phased stimulus checked each cycle against a behavioural tag-handshake model
module tb_tag_issue_ctrl;
  localparam int N = 2;
  localparam int MAXU = 7;
  logic clk = 0;
  logic reset, cmd_valid, cmd_ready, cmd_reuse, cmd_flush, cmd_bias_prev_sw, cmd_ddr_pe_sw;
  logic [N-1:0] tag_req, tag_reuse, tag_flush, tag_ready, ldmem_tag_ready, ldmem_tag_done;
  logic [N-1:0] compute_tag_ready, compute_tag_done, next_compute_tag, compute_bias_prev_sw;
  logic [N-1:0] stmem_tag_ready, stmem_tag_done, stmem_ddr_pe_sw;
  logic tag_bias_prev_sw, tag_ddr_pe_sw, ldmem_ready, ldmem_done, compute_ready, compute_done;
  logic compute_bias_sw, stmem_ready, stmem_done, stmem_sw, drained, proto_err;
  int errors = 0, checks = 0;
  int ip, lp, cp, sp;
  int uses [N];
  bit opened, closing, err;
  logic e_crdy, e_lrdy, e_cprdy, e_srdy, e_drained, e_err;
  logic [N-1:0] e_req, e_reuse, e_flush, e_ldone, e_cdone, e_sdone;
  int p_valid, p_reuse, p_flush, p_done;
  int blocked = 0;
  always #5 clk = ~clk;
  tag_issue_ctrl #(.NUM_TAGS(N), .MAX_USES(MAXU)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_reuse(cmd_reuse), .cmd_flush(cmd_flush), .cmd_bias_prev_sw(cmd_bias_prev_sw),
    .cmd_ddr_pe_sw(cmd_ddr_pe_sw), .tag_req(tag_req), .tag_reuse(tag_reuse), .tag_flush(tag_flush),
    .tag_bias_prev_sw(tag_bias_prev_sw), .tag_ddr_pe_sw(tag_ddr_pe_sw), .tag_ready(tag_ready),
    .ldmem_tag_ready(ldmem_tag_ready), .ldmem_tag_done(ldmem_tag_done),
    .compute_tag_ready(compute_tag_ready), .compute_tag_done(compute_tag_done),
    .next_compute_tag(next_compute_tag), .compute_bias_prev_sw(compute_bias_prev_sw),
    .stmem_tag_ready(stmem_tag_ready), .stmem_tag_done(stmem_tag_done),
    .stmem_ddr_pe_sw(stmem_ddr_pe_sw), .ldmem_ready(ldmem_ready), .ldmem_done(ldmem_done),
    .compute_ready(compute_ready), .compute_done(compute_done), .compute_bias_sw(compute_bias_sw),
    .stmem_ready(stmem_ready), .stmem_done(stmem_done), .stmem_sw(stmem_sw),
    .drained(drained), .proto_err(proto_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [N-1:0] rnd_vec(input int pct);
    logic [N-1:0] v;
    for (int t = 0; t < N; t++) v[t] = $urandom_range(0, 99) < pct;
    return v;
  endfunction
  task automatic model_expect;
    int ix_l, ix_c, ix_s;
    e_req = '0; e_reuse = '0; e_flush = '0; e_ldone = '0; e_cdone = '0; e_sdone = '0;
    e_crdy = 0; e_drained = 0; e_err = 0;
    ix_l = reset ? 0 : lp;
    ix_c = reset ? 0 : cp;
    ix_s = reset ? 0 : sp;
    e_lrdy = ldmem_tag_ready[ix_l];
    e_cprdy = compute_tag_ready[ix_c];
    e_srdy = stmem_tag_ready[ix_s];
    if (!reset) begin
      if (ldmem_done && e_lrdy) e_ldone[lp] = 1;
      if (compute_done && e_cprdy) e_cdone[cp] = 1;
      if (stmem_done && e_srdy) e_sdone[sp] = 1;
      if (closing) e_flush[ip] = 1;
      else if (!opened) begin
        e_crdy = cmd_reuse ? 1'b1 : tag_ready[ip];
        if (cmd_valid && e_crdy && !cmd_reuse) e_req[ip] = 1;
      end else if (cmd_reuse) begin
        e_crdy = uses[ip] < MAXU;
        if (cmd_valid && e_crdy) e_reuse[ip] = 1;
        if (cmd_valid && !e_crdy) blocked++;
      end else if (cmd_valid) e_flush[ip] = 1;
      e_drained = !opened && !closing && &tag_ready;
      e_err = err;
    end
  endtask
  task automatic model_update;
    int v;
    if (reset) begin
      ip = 0; lp = 0; cp = 0; sp = 0; opened = 0; closing = 0; err = 0;
      for (int t = 0; t < N; t++) uses[t] = 0;
      return;
    end
    if ((ldmem_done && !e_lrdy) || (compute_done && !e_cprdy) || (stmem_done && !e_srdy)) err = 1;
    if (!opened && !closing && cmd_valid && cmd_reuse) err = 1;
    for (int t = 0; t < N; t++) begin
      v = uses[t] + int'(e_req[t]) + int'(e_reuse[t]) - int'(e_cdone[t]);
      if (v < 0) begin
        v = 0;
        err = 1;
      end
      uses[t] = v;
    end
    if (|e_ldone) lp = (lp + 1) % N;
    if (|e_sdone) sp = (sp + 1) % N;
    if (next_compute_tag[cp]) cp = (cp + 1) % N;
    if (|e_flush) begin
      opened = 0;
      closing = 0;
      ip = (ip + 1) % N;
    end else if (|e_req) begin
      opened = 1;
      closing = cmd_flush;
    end else if (|e_reuse && cmd_flush) closing = 1;
  endtask
  initial begin
    reset = 1; cmd_valid = 0; cmd_reuse = 0; cmd_flush = 0; cmd_bias_prev_sw = 0; cmd_ddr_pe_sw = 0;
    tag_ready = '1; ldmem_tag_ready = '0; compute_tag_ready = '0; stmem_tag_ready = '0;
    next_compute_tag = '0; compute_bias_prev_sw = '0; stmem_ddr_pe_sw = '0;
    ldmem_done = 0; compute_done = 0; stmem_done = 0;
    ip = 0; lp = 0; cp = 0; sp = 0; opened = 0; closing = 0; err = 0;
    for (int t = 0; t < N; t++) uses[t] = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      case ((c / 250) % 4)
        0: begin p_valid = 60; p_reuse = 30; p_flush = 50; p_done = 40; end
        1: begin p_valid = 85; p_reuse = 95; p_flush = 2;  p_done = 4;  end
        2: begin p_valid = 70; p_reuse = 60; p_flush = 20; p_done = 60; end
        default: begin p_valid = 50; p_reuse = 50; p_flush = 30; p_done = 30; end
      endcase
      reset = c < 2 || $urandom_range(0, 149) == 0;
      cmd_valid = $urandom_range(0, 99) < p_valid;
      cmd_reuse = $urandom_range(0, 99) < p_reuse;
      cmd_flush = $urandom_range(0, 99) < p_flush;
      cmd_bias_prev_sw = $urandom_range(0, 1) == 1;
      cmd_ddr_pe_sw = $urandom_range(0, 1) == 1;
      tag_ready = rnd_vec(85);
      ldmem_tag_ready = rnd_vec(85);
      compute_tag_ready = rnd_vec(85);
      stmem_tag_ready = rnd_vec(85);
      next_compute_tag = rnd_vec(20);
      compute_bias_prev_sw = rnd_vec(50);
      stmem_ddr_pe_sw = rnd_vec(50);
      ldmem_done = $urandom_range(0, 99) < 40;
      compute_done = $urandom_range(0, 99) < p_done;
      stmem_done = $urandom_range(0, 99) < 40;
      #1;
      model_expect;
      chk("cmd_ready", 32'(cmd_ready), 32'(e_crdy));
      chk("tag_req", 32'(tag_req), 32'(e_req));
      chk("tag_reuse", 32'(tag_reuse), 32'(e_reuse));
      chk("tag_flush", 32'(tag_flush), 32'(e_flush));
      chk("ldmem_tag_done", 32'(ldmem_tag_done), 32'(e_ldone));
      chk("compute_tag_done", 32'(compute_tag_done), 32'(e_cdone));
      chk("stmem_tag_done", 32'(stmem_tag_done), 32'(e_sdone));
      chk("ldmem_ready", 32'(ldmem_ready), 32'(e_lrdy));
      chk("compute_ready", 32'(compute_ready), 32'(e_cprdy));
      chk("stmem_ready", 32'(stmem_ready), 32'(e_srdy));
      chk("compute_bias_sw", 32'(compute_bias_sw), 32'(compute_bias_prev_sw[reset ? 0 : cp]));
      chk("stmem_sw", 32'(stmem_sw), 32'(stmem_ddr_pe_sw[reset ? 0 : sp]));
      chk("tag_bias_prev_sw", 32'(tag_bias_prev_sw), 32'(!reset && cmd_bias_prev_sw));
      chk("tag_ddr_pe_sw", 32'(tag_ddr_pe_sw), 32'(!reset && cmd_ddr_pe_sw));
      chk("drained", 32'(drained), 32'(e_drained));
      chk("proto_err", 32'(proto_err), 32'(e_err));
      @(posedge clk);
      model_update;
    end
    chk("saturation_seen", 32'(blocked > 0), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
